// File: rtl/prism_cfg_pkg.sv
// Shared types and sizing for the PRISM configuration-chain sequencer.
package prism_cfg_pkg;

    localparam int PRISM_CFG_WIDTH = 48;
    localparam int PRISM_CFG_DEPTH = 8;
    localparam int IDX_W           = $clog2(PRISM_CFG_DEPTH);
    localparam int TMR_W           = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/prism_cfg_timer.sv
// Down-counter shared by the halt-ack timeout and the inter-pulse gap.
module prism_cfg_timer
    import prism_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - TMR_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/prism_cfg_sequencer.sv
// Stages a configuration word from two bus writes, halts PRISM, then shifts it
// into the latch chain with one-hot, non-overlapping, registered enables.
//
//   state | meaning
//   IDLE  | accepting writes; wr_hi commits the staged word
//   HALT  | halt_req asserted, waiting for halt_ack or timeout
//   PULSE | one latch_en bit high for this cycle
//   GAP   | all enables low for GAP_CYCLES cycles
//   DONE  | done pulse, load_count bump, release halt next edge
module prism_cfg_sequencer
    import prism_cfg_pkg::*;
#(
    parameter int WIDTH        = PRISM_CFG_WIDTH,
    parameter int DEPTH        = PRISM_CFG_DEPTH,
    parameter int GAP_CYCLES   = 1,
    parameter int HALT_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    input  logic             clr_err,
    input  logic             halt_ack,
    output logic [WIDTH-1:0] config_data,
    output logic [DEPTH-1:0] latch_en,
    output logic             halt_req,
    output logic             busy,
    output logic             done,
    output logic [3:0]       load_count,
    output logic             err_overrun,
    output logic             err_timeout
);

    localparam int IW = (DEPTH == PRISM_CFG_DEPTH) ? IDX_W : $clog2(DEPTH);
    localparam int HW = WIDTH - 32;

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nx;
    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] stage_nx;
    logic [DEPTH-1:0] latch_nx;

    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_zero;
    logic [TMR_W-1:0] tmr_val;

    logic             timeout_evt;
    logic             overrun_evt;
    logic             count_evt;

    prism_cfg_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        stage_nx = stage;
        if (wr_lo) begin
            stage_nx[31:0] = wdata;
        end
        if (wr_hi) begin
            stage_nx[WIDTH-1:32] = wdata[HW-1:0];
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_en      = 1'b0;
        timeout_evt = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_hi) begin
                    state_nx = HALT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HALT_TIMEOUT - 1);
                end
            end
            HALT: begin
                tmr_en = 1'b1;
                if (halt_ack) begin
                    state_nx = PULSE;
                    idx_nx   = IW'(DEPTH - 1);
                end else if (tmr_zero) begin
                    // No ack in time: flag it and reconfigure regardless.
                    timeout_evt = 1'b1;
                    state_nx    = PULSE;
                    idx_nx      = IW'(DEPTH - 1);
                end
            end
            PULSE: begin
                state_nx = GAP;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(GAP_CYCLES - 1);
            end
            GAP: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    if (idx == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = PULSE;
                        idx_nx   = idx - IW'(1);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Enables are decoded from the next state so each bit comes straight off a flop.
    always_comb begin
        latch_nx = '0;
        if (state_nx == PULSE) begin
            latch_nx[idx_nx] = 1'b1;
        end
    end

    assign overrun_evt = (wr_lo || wr_hi) && (state != IDLE);
    assign count_evt   = (state_nx == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            stage       <= '0;
            config_data <= '0;
            latch_en    <= '0;
            halt_req    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_count  <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            latch_en <= latch_nx;
            halt_req <= (state_nx != IDLE);
            busy     <= (state_nx != IDLE);
            done     <= (state_nx == DONE);

            if (state == IDLE) begin
                stage <= stage_nx;
                if (wr_hi) begin
                    config_data <= stage_nx;
                end
            end

            err_overrun <= overrun_evt || (err_overrun && !clr_err);
            err_timeout <= timeout_evt || (err_timeout && !clr_err);

            if (clr_err) begin
                load_count <= count_evt ? 4'd1 : 4'd0;
            end else if (count_evt && (load_count != 4'(DEPTH))) begin
                load_count <= load_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_prism_cfg_sequencer.sv
// Directed bench: two sequencers (gap 1 and gap 3) share stimulus; each output
// is compared per cycle against a hand-derived timing table.
module tb_prism_cfg_sequencer;
    import prism_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, wr_lo, wr_hi, clr_err, halt_ack;
    logic [31:0] wdata;

    logic [47:0] cfg_a, cfg_b;
    logic [7:0]  len_a, len_b;
    logic        hreq_a, hreq_b, busy_a, busy_b, done_a, done_b;
    logic [3:0]  lc_a, lc_b;
    logic        ovr_a, ovr_b, tmo_a, tmo_b;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    prism_cfg_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_lo(wr_lo), .wr_hi(wr_hi), .wdata(wdata),
        .clr_err(clr_err), .halt_ack(halt_ack), .config_data(cfg_a), .latch_en(len_a),
        .halt_req(hreq_a), .busy(busy_a), .done(done_a), .load_count(lc_a),
        .err_overrun(ovr_a), .err_timeout(tmo_a)
    );

    prism_cfg_sequencer #(.GAP_CYCLES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_lo(wr_lo), .wr_hi(wr_hi), .wdata(wdata),
        .clr_err(clr_err), .halt_ack(halt_ack), .config_data(cfg_b), .latch_en(len_b),
        .halt_req(hreq_b), .busy(busy_b), .done(done_b), .load_count(lc_b),
        .err_overrun(ovr_b), .err_timeout(tmo_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {latch_en, done, busy, halt_req} n edges after the commit, halt_ack high.
    function automatic logic [10:0] seq_exp(input int gap, input int n);
        int         dn;
        logic [7:0] le;
        dn = 2 + (gap + 1) * 8;
        le = '0;
        if (n >= 2 && n < dn && ((n - 2) % (gap + 1)) == 0) begin
            le[7 - (n - 2) / (gap + 1)] = 1'b1;
        end
        return {le, (n == dn), (n >= 1 && n <= dn), (n >= 1 && n <= dn)};
    endfunction

    // Caller drives the commit; n=1 is the edge that samples it.
    task automatic run_seq(input string tag, input logic [47:0] cfg, input int inj_n);
        for (int n = 1; n <= 36; n++) begin
            tick();
            wr_lo = 1'b0;
            wr_hi = 1'b0;
            chk($sformatf("%s_a_c%0d", tag, n), {len_a, done_a, busy_a, hreq_a}, seq_exp(1, n));
            chk($sformatf("%s_b_c%0d", tag, n), {len_b, done_b, busy_b, hreq_b}, seq_exp(3, n));
            chk($sformatf("%s_cfga_c%0d", tag, n), cfg_a, cfg);
            chk($sformatf("%s_cfgb_c%0d", tag, n), cfg_b, cfg);
            if (n == inj_n) begin
                wr_hi = 1'b1;
                wdata = 32'h0000_FFFF;
            end
        end
    endtask

    initial begin
        logic [47:0] cfg;
        rst_n    = 1'b0;
        wr_lo    = 1'b0;
        wr_hi    = 1'b0;
        clr_err  = 1'b0;
        halt_ack = 1'b1;
        wdata    = '0;
        repeat (3) tick();

        chk("rst_a", {cfg_a, len_a, hreq_a, busy_a, done_a, lc_a, ovr_a, tmo_a}, 64'd0);
        chk("rst_b", {cfg_b, len_b, hreq_b, busy_b, done_b, lc_b, ovr_b, tmo_b}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic two-write load.
        wr_lo = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        wr_lo = 1'b0;
        wr_hi = 1'b1;
        wdata = 32'h0000_1234;
        run_seq("t1", 48'h1234_DEAD_BEEF, 0);
        chk("t1_lc_a", lc_a, 4'd1);
        chk("t1_lc_b", lc_b, 4'd1);

        // halt_ack never arrives.
        halt_ack = 1'b0;
        wr_hi    = 1'b1;
        wdata    = 32'h0000_1234;
        for (int n = 1; n <= 18; n++) begin
            tick();
            wr_hi = 1'b0;
            if (n == 15) begin
                chk("t2_pre_a", {tmo_a, busy_a, len_a}, {1'b0, 1'b1, 8'h00});
                chk("t2_pre_b", {tmo_b, busy_b, len_b}, {1'b0, 1'b1, 8'h00});
            end
            if (n == 16) begin
                chk("t2_tmo_a", {tmo_a, len_a}, {1'b1, 8'h80});
                chk("t2_tmo_b", {tmo_b, len_b}, {1'b1, 8'h80});
            end
            if (n == 18) begin
                chk("t2_p6_a", len_a, 8'h40);
            end
        end
        for (int k = 0; k < 80; k++) begin
            if (!busy_a && !busy_b) break;
            tick();
        end
        chk("t2_idle", {busy_a, busy_b}, 2'b00);
        chk("t2_lc", {lc_a, lc_b}, {4'd2, 4'd2});
        chk("t2_sticky", {tmo_a, tmo_b}, 2'b11);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t2_clr", {tmo_a, tmo_b, lc_a, lc_b}, {2'b00, 4'd0, 4'd0});
        halt_ack = 1'b1;

        // Write during PULSE is rejected and flagged.
        wr_hi = 1'b1;
        wdata = 32'h0000_1234;
        run_seq("t3", 48'h1234_DEAD_BEEF, 2);
        chk("t3_ovr", {ovr_a, ovr_b}, 2'b11);
        chk("t3_lc", {lc_a, lc_b}, {4'd1, 4'd1});

        // Reset in the middle of the chain shift.
        wr_lo = 1'b1;
        wdata = 32'hA5A5_A5A5;
        tick();
        wr_lo = 1'b0;
        wr_hi = 1'b1;
        wdata = 32'h0000_0077;
        for (int n = 1; n <= 8; n++) begin
            tick();
            wr_hi = 1'b0;
        end
        chk("t4_pulse4", len_a, 8'h10);
        rst_n = 1'b0;
        tick();
        chk("t4_rst_a", {len_a, hreq_a, busy_a, lc_a, ovr_a, cfg_a}, 64'd0);
        chk("t4_rst_b", {len_b, hreq_b, busy_b, lc_b, ovr_b, cfg_b}, 64'd0);
        rst_n = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hCAFE_F00D;
        tick();
        wr_lo = 1'b0;
        wr_hi = 1'b1;
        wdata = 32'h0000_5A5A;
        run_seq("t4b", 48'h5A5A_CAFE_F00D, 0);
        chk("t4_lc", {lc_a, lc_b}, {4'd1, 4'd1});

        // Nine back-to-back loads; count saturates at DEPTH.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cfg   = {16'(i + 1), 32'h0};
            wr_hi = 1'b1;
            wdata = 32'(i + 1);
            run_seq($sformatf("t5_%0d", i), cfg, 0);
            chk($sformatf("t5_lc_a%0d", i), lc_a, (i < 8) ? 4'(i + 1) : 4'd8);
            chk($sformatf("t5_lc_b%0d", i), lc_b, (i < 8) ? 4'(i + 1) : 4'd8);
        end

        // Both halves in one cycle from the shared wdata.
        wr_lo = 1'b1;
        wr_hi = 1'b1;
        wdata = 32'h1111_2222;
        run_seq("t6", 48'h2222_1111_2222, 0);
        chk("t6_lc", {lc_a, lc_b}, {4'd8, 4'd8});
        chk("t6_flags", {ovr_a, tmo_a, ovr_b, tmo_b}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
